// File: rtl/store_buffer_ctrl.sv
// Speculative store buffer between MEM and the dcache: stores enter PENDING, retire
// in order to COMMITTED or CANCELLED, and committed stores drain one at a time.
module store_buffer_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_valid_i,
  input  logic [31:0] push_addr_i,
  input  logic [31:0] push_data_i,
  input  logic [3:0]  push_wstrb_i,
  output logic        push_ready_o,
  input  logic        commit_i,
  input  logic        cancel_i,
  input  logic        flush_i,
  output logic        wr_req_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_strb_o,
  input  logic        wr_ready_i,
  input  logic [31:0] query_addr_i,
  output logic        query_hit_o,
  output logic        sb_empty_o,
  output logic [0:0]  dbg_drain_state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_COMM  = 2'd2;
  localparam logic [1:0] ST_CANC  = 2'd3;

  localparam logic [0:0] DR_IDLE = 1'b0;
  localparam logic [0:0] DR_REQ  = 1'b1;

  logic [1:0]    ent_st_q   [DEPTH];
  logic [1:0]    ent_st_d   [DEPTH];
  logic [31:0]   ent_addr_q [DEPTH];
  logic [31:0]   ent_addr_d [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [31:0]   ent_data_d [DEPTH];
  logic [3:0]    ent_strb_q [DEPTH];
  logic [3:0]    ent_strb_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] cptr_q, cptr_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [0:0]    drain_q, drain_d;

  logic          push_fire;
  logic          release_head;
  logic [PW:0]   n_flushed;
  logic          unused_query_lsb;

  // Handshakes: push fires on push_valid_i & push_ready_o; a cache write completes
  // on wr_req_o & wr_ready_i, with the payload held from the head entry meanwhile.
  assign push_ready_o = (count_q < DEPTH_C) & ~flush_i;
  assign push_fire    = push_valid_i & push_ready_o;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_st_d[i]   = ent_st_q[i];
      ent_addr_d[i] = ent_addr_q[i];
      ent_data_d[i] = ent_data_q[i];
      ent_strb_d[i] = ent_strb_q[i];
    end
    head_d       = head_q;
    cptr_d       = cptr_q;
    tail_d       = tail_q;
    drain_d      = drain_q;
    release_head = 1'b0;
    n_flushed    = '0;

    if (push_fire) begin
      ent_st_d[tail_q]   = ST_PEND;
      ent_addr_d[tail_q] = push_addr_i;
      ent_data_d[tail_q] = push_data_i;
      ent_strb_d[tail_q] = push_wstrb_i;
      tail_d             = tail_q + 1'b1;
    end

    // Commit takes priority over cancel; both only act on a PENDING entry.
    if ((commit_i | cancel_i) && ent_st_q[cptr_q] == ST_PEND) begin
      ent_st_d[cptr_q] = commit_i ? ST_COMM : ST_CANC;
      cptr_d           = cptr_q + 1'b1;
    end

    case (drain_q)
      DR_IDLE: begin
        if (ent_st_q[head_q] == ST_COMM) begin
          drain_d = DR_REQ;
        end else if (ent_st_q[head_q] == ST_CANC) begin
          ent_st_d[head_q] = ST_EMPTY;
          head_d           = head_q + 1'b1;
          release_head     = 1'b1;
        end
      end
      default: begin
        if (wr_ready_i) begin
          ent_st_d[head_q] = ST_EMPTY;
          head_d           = head_q + 1'b1;
          release_head     = 1'b1;
          drain_d          = DR_IDLE;
        end
      end
    endcase

    // Flush sees the retire of this cycle, so only still-PENDING entries vanish.
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_st_d[i] == ST_PEND) begin
          ent_st_d[i] = ST_EMPTY;
          n_flushed   = n_flushed + 1'b1;
        end
      end
      tail_d = cptr_d;
    end

    count_d = count_q + {{PW{1'b0}}, push_fire} - {{PW{1'b0}}, release_head} - n_flushed;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_st_q[i]   <= ST_EMPTY;
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
        ent_strb_q[i] <= '0;
      end
      head_q  <= '0;
      cptr_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drain_q <= DR_IDLE;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_st_q[i]   <= ent_st_d[i];
        ent_addr_q[i] <= ent_addr_d[i];
        ent_data_q[i] <= ent_data_d[i];
        ent_strb_q[i] <= ent_strb_d[i];
      end
      head_q  <= head_d;
      cptr_q  <= cptr_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drain_q <= drain_d;
    end
  end

  assign wr_req_o          = (drain_q == DR_REQ);
  assign wr_addr_o         = wr_req_o ? ent_addr_q[head_q] : '0;
  assign wr_data_o         = wr_req_o ? ent_data_q[head_q] : '0;
  assign wr_strb_o         = wr_req_o ? ent_strb_q[head_q] : '0;
  assign sb_empty_o        = (count_q == '0);
  assign dbg_drain_state_o = drain_q;
  assign unused_query_lsb  = ^query_addr_i[1:0];

  // Word-granular hazard check; only live (PENDING/COMMITTED) entries count.
  always_comb begin
    query_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((ent_st_q[i] == ST_PEND || ent_st_q[i] == ST_COMM) &&
          ent_addr_q[i][31:2] == query_addr_i[31:2]) begin
        query_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed cycle-vector bench for store_buffer_ctrl (DEPTH=4) with a scoreboard of
// the store addresses expected to reach the dcache, in order.
module tb_store_buffer_ctrl;

  logic        clk;
  logic        rst_n;
  logic        push_valid_i;
  logic [31:0] push_addr_i;
  logic [31:0] push_data_i;
  logic [3:0]  push_wstrb_i;
  logic        push_ready_o;
  logic        commit_i;
  logic        cancel_i;
  logic        flush_i;
  logic        wr_req_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic [3:0]  wr_strb_o;
  logic        wr_ready_i;
  logic [31:0] query_addr_i;
  logic        query_hit_o;
  logic        sb_empty_o;
  logic [0:0]  dbg_drain_state;

  store_buffer_ctrl #(.DEPTH(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .push_valid_i      (push_valid_i),
    .push_addr_i       (push_addr_i),
    .push_data_i       (push_data_i),
    .push_wstrb_i      (push_wstrb_i),
    .push_ready_o      (push_ready_o),
    .commit_i          (commit_i),
    .cancel_i          (cancel_i),
    .flush_i           (flush_i),
    .wr_req_o          (wr_req_o),
    .wr_addr_o         (wr_addr_o),
    .wr_data_o         (wr_data_o),
    .wr_strb_o         (wr_strb_o),
    .wr_ready_i        (wr_ready_i),
    .query_addr_i      (query_addr_i),
    .query_hit_o       (query_hit_o),
    .sb_empty_o        (sb_empty_o),
    .dbg_drain_state_o (dbg_drain_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] tag;
    logic        rst_n;
    logic        pv;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        cm;
    logic        cn;
    logic        fl;
    logic        wr;
    logic [31:0] qa;
    logic        e_prdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_strb;
    logic        e_hit;
    logic        e_empty;
    logic        pchk;
  } vec_t;

  vec_t        tv[$];
  logic [31:0] exp_q[$];
  int          n_vec;
  int          n_miss;

  function automatic vec_t mk(
    input logic [63:0] tag, input logic rst, input logic pv, input logic [31:0] addr,
    input logic [31:0] data, input logic [3:0] strb, input logic cm, input logic cn,
    input logic fl, input logic wr, input logic [31:0] qa, input logic e_prdy,
    input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_data,
    input logic [3:0] e_strb, input logic e_hit, input logic e_empty, input logic pchk);
    vec_t v;
    v.tag = tag; v.rst_n = rst; v.pv = pv; v.addr = addr; v.data = data; v.strb = strb;
    v.cm = cm; v.cn = cn; v.fl = fl; v.wr = wr; v.qa = qa;
    v.e_prdy = e_prdy; v.e_req = e_req; v.e_addr = e_addr; v.e_data = e_data;
    v.e_strb = e_strb; v.e_hit = e_hit; v.e_empty = e_empty; v.pchk = pchk | e_req;
    return v;
  endfunction

  // driver: inputs change at negedge, outputs sampled 1ns later, edge applies at posedge
  task automatic apply(input vec_t v);
    logic ok;
    logic [31:0] ea;
    @(negedge clk);
    rst_n        = v.rst_n;
    push_valid_i = v.pv;
    push_addr_i  = v.addr;
    push_data_i  = v.data;
    push_wstrb_i = v.strb;
    commit_i     = v.cm;
    cancel_i     = v.cn;
    flush_i      = v.fl;
    wr_ready_i   = v.wr;
    query_addr_i = v.qa;
    #1;
    n_vec++;
    ok = (push_ready_o === v.e_prdy) && (wr_req_o === v.e_req) &&
         (query_hit_o === v.e_hit) && (sb_empty_o === v.e_empty);
    if (v.pchk)
      ok = ok && (wr_addr_o === v.e_addr) && (wr_data_o === v.e_data) && (wr_strb_o === v.e_strb);
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got prdy=%b req=%b addr=%h data=%h strb=%h hit=%b empty=%b; want prdy=%b req=%b addr=%h data=%h strb=%h hit=%b empty=%b",
               v.tag, push_ready_o, wr_req_o, wr_addr_o, wr_data_o, wr_strb_o, query_hit_o, sb_empty_o,
               v.e_prdy, v.e_req, v.e_addr, v.e_data, v.e_strb, v.e_hit, v.e_empty);
    end
    // scoreboard: every completed cache write must be the next expected store
    if (rst_n && wr_req_o && wr_ready_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL %s write: got unexpected write to %h, want none", v.tag, wr_addr_o);
      end else begin
        ea = exp_q.pop_front();
        if (wr_addr_o !== ea) begin
          n_miss++;
          $display("FAIL %s write: got addr %h, want %h", v.tag, wr_addr_o, ea);
        end
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n = 1'b0; push_valid_i = 1'b0; push_addr_i = '0; push_data_i = '0; push_wstrb_i = '0;
    commit_i = 1'b0; cancel_i = 1'b0; flush_i = 1'b0; wr_ready_i = 1'b0; query_addr_i = '0;

    exp_q.push_back(32'h1000);
    exp_q.push_back(32'h3000);
    exp_q.push_back(32'h3004);
    exp_q.push_back(32'h3008);
    exp_q.push_back(32'h2004);

    // reset, then one store pushed, committed and drained
    tv.push_back(mk("rst",     0,0,32'h0,32'h0,4'h0, 0,0,0,0,32'h1000, 1,0,32'h0,32'h0,4'h0, 0,1,1));
    tv.push_back(mk("push1",   1,1,32'h1000,32'hA5A5A5A5,4'hF, 0,0,0,1,32'h1000, 1,0,32'h0,32'h0,4'h0, 0,1,1));
    tv.push_back(mk("commit1", 1,0,32'h0,32'h0,4'h0, 1,0,0,1,32'h1000, 1,0,32'h0,32'h0,4'h0, 1,0,0));
    tv.push_back(mk("wait1",   1,0,32'h0,32'h0,4'h0, 0,0,0,1,32'h1003, 1,0,32'h0,32'h0,4'h0, 1,0,0));
    tv.push_back(mk("req1",    1,0,32'h0,32'h0,4'h0, 0,0,0,1,32'h1000, 1,1,32'h1000,32'hA5A5A5A5,4'hF, 1,0,0));
    tv.push_back(mk("empty1",  1,0,32'h0,32'h0,4'h0, 0,0,0,1,32'h1000, 1,0,32'h0,32'h0,4'h0, 0,1,0));
    // fill to DEPTH, fifth push held off until one entry drains
    tv.push_back(mk("fill0",   1,1,32'h3000,32'h11111111,4'h1, 0,0,0,0,32'h0, 1,0,32'h0,32'h0,4'h0, 0,1,0));
    tv.push_back(mk("fill1",   1,1,32'h3004,32'h22222222,4'h3, 0,0,0,0,32'h0, 1,0,32'h0,32'h0,4'h0, 0,0,0));
    tv.push_back(mk("fill2",   1,1,32'h3008,32'h33333333,4'hC, 0,0,0,0,32'h0, 1,0,32'h0,32'h0,4'h0, 0,0,0));
    tv.push_back(mk("fill3",   1,1,32'h300C,32'h44444444,4'hF, 0,0,0,0,32'h0, 1,0,32'h0,32'h0,4'h0, 0,0,0));
    tv.push_back(mk("full",    1,1,32'h3010,32'h55555555,4'hF, 0,0,0,0,32'h3010, 0,0,32'h0,32'h0,4'h0, 0,0,0));
    tv.push_back(mk("fullcm",  1,1,32'h3010,32'h55555555,4'hF, 1,0,0,0,32'h3008, 0,0,32'h0,32'h0,4'h0, 1,0,0));
    tv.push_back(mk("fullno5", 1,0,32'h0,32'h0,4'h0, 0,0,0,0,32'h3010, 0,0,32'h0,32'h0,4'h0, 0,0,0));
    tv.push_back(mk("drain0",  1,0,32'h0,32'h0,4'h0, 0,0,0,1,32'h0, 0,1,32'h3000,32'h11111111,4'h1, 0,0,0));
    tv.push_back(mk("refill",  1,1,32'h3010,32'h55555555,4'hF, 0,0,0,0,32'h0, 1,0,32'h0,32'h0,4'h0, 0,0,0));
    // two committed, two pending, flush while the first is stalled in REQ
    tv.push_back(mk("cm_a",    1,0,32'h0,32'h0,4'h0, 1,0,0,0,32'h0, 0,0,32'h0,32'h0,4'h0, 0,0,0));
    tv.push_back(mk("cm_b",    1,0,32'h0,32'h0,4'h0, 1,0,0,0,32'h300C, 0,0,32'h0,32'h0,4'h0, 1,0,0));
    tv.push_back(mk("stall1",  1,0,32'h0,32'h0,4'h0, 0,0,1,0,32'h300C, 0,1,32'h3004,32'h22222222,4'h3, 1,0,0));
    tv.push_back(mk("stall2",  1,0,32'h0,32'h0,4'h0, 0,0,0,0,32'h300C, 1,1,32'h3004,32'h22222222,4'h3, 0,0,0));
    tv.push_back(mk("stall3",  1,0,32'h0,32'h0,4'h0, 0,0,0,0,32'h3010, 1,1,32'h3004,32'h22222222,4'h3, 0,0,0));
    tv.push_back(mk("stall4",  1,0,32'h0,32'h0,4'h0, 0,0,0,0,32'h3008, 1,1,32'h3004,32'h22222222,4'h3, 1,0,0));
    tv.push_back(mk("stall5",  1,0,32'h0,32'h0,4'h0, 0,0,1,0,32'h3004, 0,1,32'h3004,32'h22222222,4'h3, 1,0,0));
    tv.push_back(mk("drain_a", 1,0,32'h0,32'h0,4'h0, 0,0,0,1,32'h0, 1,1,32'h3004,32'h22222222,4'h3, 0,0,0));
    tv.push_back(mk("gap_b",   1,0,32'h0,32'h0,4'h0, 0,0,0,1,32'h0, 1,0,32'h0,32'h0,4'h0, 0,0,0));
    tv.push_back(mk("drain_b", 1,0,32'h0,32'h0,4'h0, 0,0,0,1,32'h0, 1,1,32'h3008,32'h33333333,4'hC, 0,0,0));
    // cancel the older store, commit the younger: only the younger reaches the cache
    tv.push_back(mk("push_A",  1,1,32'h2000,32'hAAAA0000,4'hF, 0,0,0,0,32'h0, 1,0,32'h0,32'h0,4'h0, 0,1,0));
    tv.push_back(mk("push_B",  1,1,32'h2004,32'hBBBB0004,4'h5, 0,0,0,0,32'h2000, 1,0,32'h0,32'h0,4'h0, 1,0,0));
    tv.push_back(mk("cancelA", 1,0,32'h0,32'h0,4'h0, 0,1,0,0,32'h2000, 1,0,32'h0,32'h0,4'h0, 1,0,0));
    tv.push_back(mk("commitB", 1,0,32'h0,32'h0,4'h0, 1,0,0,0,32'h2000, 1,0,32'h0,32'h0,4'h0, 0,0,0));
    tv.push_back(mk("idleB",   1,0,32'h0,32'h0,4'h0, 0,0,0,1,32'h2004, 1,0,32'h0,32'h0,4'h0, 1,0,0));
    tv.push_back(mk("drainB",  1,0,32'h0,32'h0,4'h0, 0,0,0,1,32'h0, 1,1,32'h2004,32'hBBBB0004,4'h5, 0,0,0));
    // commit with nothing pending is ignored; commit beats cancel; reset mid-REQ
    tv.push_back(mk("cm_none", 1,1,32'h4000,32'h44440000,4'hF, 1,0,0,0,32'h0, 1,0,32'h0,32'h0,4'h0, 0,1,0));
    tv.push_back(mk("cm_cn",   1,1,32'h4004,32'h44440004,4'h3, 1,1,0,0,32'h4000, 1,0,32'h0,32'h0,4'h0, 1,0,0));
    tv.push_back(mk("push3",   1,1,32'h4008,32'h44440008,4'hF, 0,0,0,0,32'h4000, 1,0,32'h0,32'h0,4'h0, 1,0,0));
    tv.push_back(mk("req_rst", 1,0,32'h0,32'h0,4'h0, 0,0,0,0,32'h4008, 1,1,32'h4000,32'h44440000,4'hF, 1,0,0));
    tv.push_back(mk("rst_req", 0,0,32'h0,32'h0,4'h0, 0,0,0,0,32'h4008, 1,1,32'h4000,32'h44440000,4'hF, 1,0,0));
    tv.push_back(mk("post_rst",1,0,32'h0,32'h0,4'h0, 0,0,0,0,32'h4008, 1,0,32'h0,32'h0,4'h0, 0,1,1));
    tv.push_back(mk("fl_prdy", 1,0,32'h0,32'h0,4'h0, 0,0,1,0,32'h0, 0,0,32'h0,32'h0,4'h0, 0,1,0));

    repeat (2) @(posedge clk);
    foreach (tv[i]) apply(tv[i]);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL missing_writes: got %0d expected writes outstanding, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
